load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DMEM_DATA_WIDTH, default 32, the data width; only 32 is supported.
REQ-002 SHALL have parameter DMEM_ADDR_WIDTH, default 12, the byte-address width of the data memory.
REQ-003 SHALL have parameter SPLIT_MISALIGNED, default 1: 1 = split misaligned accesses into byte accesses, 0 = reject them as errors.
REQ-004 SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have these request ports:
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  DMEM_ADDR_WIDTH  byte address.
- req_wdata  in  32  store data.
REQ-006 SHALL have these response ports:
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  invalid or rejected request.
REQ-007 SHALL have these data-memory ports:
- mem_wr_en  out  1  write enable.
- mem_rw_mode  out  2  access size: BYTE, HALFWORD or WORD.
- mem_addr  out  DMEM_ADDR_WIDTH  byte address.
- mem_w_data  out  32  write data.
- mem_r_data  in  32  asynchronous read data, zero-extended by the memory.

Function
REQ-008 SHALL implement states IDLE, ACCESS and RESP; req_ready = (state == IDLE).
REQ-009 SHALL capture we, funct3, addr and wdata on the accepting edge, then move IDLE -> ACCESS, or IDLE -> RESP with err=1 when the request is invalid.
REQ-010 SHALL treat as invalid: funct3 011/110/111; a store with funct3[2]=1; a misaligned access when SPLIT_MISALIGNED=0. An invalid request SHALL never assert mem_wr_en.
REQ-011 SHALL, for an aligned access (H with addr[0]=0, W with addr[1:0]=0, or any B), perform one ACCESS cycle with mem_rw_mode matching the width, then go to RESP.
REQ-012 SHALL, for a misaligned H or W, perform 2 or 4 consecutive BYTE accesses at addr+i (i = 0..n-1), using a 2-bit byte counter; addresses wrap modulo 2**DMEM_ADDR_WIDTH.
REQ-013 SHALL, for split stores, drive byte i of wdata on mem_w_data[7:0]; for split loads, collect mem_r_data[7:0] into byte i of an assembly register.
REQ-014 SHALL assert mem_wr_en only in ACCESS with a valid store; mem_wr_en = 0 and mem_rw_mode = BYTE in all other states.
REQ-015 SHALL extend loads in RESP: B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
REQ-016 SHALL pulse rsp_valid for exactly the RESP cycle, then return to IDLE; rsp_rdata and rsp_err SHALL hold until the next response.
REQ-017 SHALL give these latencies from the accept edge to rsp_valid: aligned, 2 cycles; split H, 3 cycles; split W, 5 cycles; error, 1 cycle. Throughput is one request per (latency+1) cycles.

Reset
REQ-018 SHALL, while rst=0, force state=IDLE, byte counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and mem_wr_en=0 immediately (asynchronously).
REQ-019 SHALL, on reset during ACCESS, issue no further memory writes; bytes already written stay written. After release the unit SHALL be in IDLE with req_ready=1.

Structure
REQ-020 SHALL take BYTE/HALFWORD/WORD and the funct3 codes from the shared common_library.vh; state encodings SHALL be local.
REQ-021 SHALL contain one sub-module, load_extender: combinational sign/zero extension keyed by funct3.

Verification
REQ-022 Store SW 0x8899AABB at 0x010, then LW 0x010 -> one ACCESS with mode WORD; rsp_rdata=0x8899AABB, rsp_valid 2 cycles after accept.
REQ-023 Byte 0xF0 at 0x021: LB -> 0xFFFFFFF0; LBU -> 0x000000F0.
REQ-024 SW 0x11223344 at 0x0FFE with SPLIT_MISALIGNED=1 -> byte writes 44@0FFE, 33@0FFF, 22@000, 11@001; LW 0x0FFE returns 0x11223344 after 5 cycles.
REQ-025 LH 0x003 with SPLIT_MISALIGNED=0 -> rsp_err=1, rsp_rdata=0, no mem_wr_en, 1-cycle latency; funct3=011 behaves the same.
REQ-026 rst=0 after the 2nd byte of a split SW -> exactly 2 bytes written, outputs 0 immediately, req_ready=1 after release.
REQ-027 req_valid held high continuously -> no request accepted outside IDLE; each accepted request yields exactly one rsp_valid pulse.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared access-size codes, RISC-V load/store width codes and decode helpers
// for the load/store unit.
package load_store_unit_pkg;

  localparam logic [1:0] BYTE     = 2'b00;
  localparam logic [1:0] HALFWORD = 2'b01;
  localparam logic [1:0] WORD     = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [1:0] f3_mode(input logic [2:0] f3);
    case (f3[1:0])
      2'b01:   return HALFWORD;
      2'b10:   return WORD;
      default: return BYTE;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// Combinational sign/zero extension of raw load data, keyed by funct3.
module load_extender
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [31:0] result
);

  always_comb begin
    result = data;
    case (funct3)
      F3_B:    result = {{24{data[7]}}, data[7:0]};
      F3_H:    result = {{16{data[15]}}, data[15:0]};
      F3_BU:   result = {24'b0, data[7:0]};
      F3_HU:   result = {16'b0, data[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time through IDLE -> ACCESS -> RESP, with
// misaligned halfword/word accesses optionally split into byte accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DMEM_DATA_WIDTH  = 32,
  parameter int DMEM_ADDR_WIDTH  = 12,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [DMEM_DATA_WIDTH-1:0] req_wdata,
  output logic                       rsp_valid,
  output logic [DMEM_DATA_WIDTH-1:0] rsp_rdata,
  output logic                       rsp_err,
  output logic                       mem_wr_en,
  output logic [1:0]                 mem_rw_mode,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DMEM_DATA_WIDTH-1:0] mem_w_data,
  input  logic [DMEM_DATA_WIDTH-1:0] mem_r_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic                       we_q;
  logic [2:0]                 f3_q;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q;
  logic [DMEM_DATA_WIDTH-1:0] wdata_q;
  logic                       split_q;
  logic                       err_q;
  logic [1:0]                 cnt;
  logic [DMEM_DATA_WIDTH-1:0] asm_q;
  logic [DMEM_DATA_WIDTH-1:0] rdata_hold;
  logic                       err_hold;

  logic                       misaligned;
  logic                       req_bad;
  logic [1:0]                 last_cnt;
  logic                       access_done;
  logic [DMEM_DATA_WIDTH-1:0] load_word;
  logic [DMEM_DATA_WIDTH-1:0] ext_data;
  logic [DMEM_DATA_WIDTH-1:0] rsp_cur;

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_bad    = !f3_legal(req_funct3) || (req_we && req_funct3[2]) ||
                      (misaligned && !SPLIT_MISALIGNED);

  assign last_cnt    = (f3_q[1:0] == 2'b10) ? 2'd3 : 2'd1;
  assign access_done = !split_q || (cnt == last_cnt);

  // Split loads merge the current byte into the assembly register.
  always_comb begin
    load_word = mem_r_data;
    if (split_q) begin
      load_word = asm_q;
      load_word[{cnt, 3'b000} +: 8] = mem_r_data[7:0];
    end
  end

  load_extender u_ext (
    .funct3 (f3_q),
    .data   (asm_q),
    .result (ext_data)
  );

  assign rsp_cur   = (we_q || err_q) ? '0 : ext_data;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (state == RESP) ? rsp_cur : rdata_hold;
  assign rsp_err   = (state == RESP) ? err_q : err_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_bad ? RESP : ACCESS;
      ACCESS:  if (access_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      split_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt        <= 2'd0;
      asm_q      <= '0;
      rdata_hold <= '0;
      err_hold   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            split_q <= misaligned;
            err_q   <= req_bad;
            cnt     <= 2'd0;
            asm_q   <= '0;
          end
        end
        ACCESS: begin
          asm_q <= load_word;
          if (!access_done) cnt <= cnt + 2'd1;
        end
        RESP: begin
          rdata_hold <= rsp_cur;
          err_hold   <= err_q;
          cnt        <= 2'd0;
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

  // Only a validated request ever reaches ACCESS, so we_q alone gates writes.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_rw_mode = BYTE;
    mem_addr    = addr_q;
    mem_w_data  = '0;
    if (state == ACCESS) begin
      mem_wr_en = we_q;
      if (split_q) begin
        mem_addr   = addr_q + DMEM_ADDR_WIDTH'(cnt);
        mem_w_data = DMEM_DATA_WIDTH'(wdata_q[{cnt, 3'b000} +: 8]);
      end else begin
        mem_rw_mode = f3_mode(f3_q);
        mem_w_data  = wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a split-enabled instance backed by a
// byte memory model, plus a reject-misaligned instance with constant read data.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_we, req_ready, rsp_valid, rsp_err, mem_wr_en;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr, mem_addr;
  logic [31:0] req_wdata, rsp_rdata, mem_w_data, mem_r_data;
  logic [1:0]  mem_rw_mode;

  logic        req_valid0, req_we0, req_ready0, rsp_valid0, rsp_err0, mem_wr_en0;
  logic [2:0]  req_funct30;
  logic [11:0] req_addr0, mem_addr0;
  logic [31:0] req_wdata0, rsp_rdata0, mem_w_data0, mem_r_data0;
  logic [1:0]  mem_rw_mode0;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int wr_count0 = 0;
  int word_cycles = 0;

  logic [7:0] mem [0:4095];

  load_store_unit #(.DMEM_DATA_WIDTH(32), .DMEM_ADDR_WIDTH(12), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_wr_en(mem_wr_en), .mem_rw_mode(mem_rw_mode), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  load_store_unit #(.DMEM_DATA_WIDTH(32), .DMEM_ADDR_WIDTH(12), .SPLIT_MISALIGNED(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_funct3(req_funct30), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .mem_wr_en(mem_wr_en0), .mem_rw_mode(mem_rw_mode0), .mem_addr(mem_addr0),
    .mem_w_data(mem_w_data0), .mem_r_data(mem_r_data0)
  );

  assign mem_r_data0 = 32'hCAFE0123;

  // Asynchronous-read memory, zero-extending by access size.
  always_comb begin
    case (mem_rw_mode)
      HALFWORD: mem_r_data = {16'b0, mem[mem_addr + 12'd1], mem[mem_addr]};
      WORD:     mem_r_data = {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2],
                              mem[mem_addr + 12'd1], mem[mem_addr]};
      default:  mem_r_data = {24'b0, mem[mem_addr]};
    endcase
  end

  // Writes land mid-cycle so the count sees each write cycle exactly once.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_count++;
      mem[mem_addr] = mem_w_data[7:0];
      if (mem_rw_mode != BYTE) mem[mem_addr + 12'd1] = mem_w_data[15:8];
      if (mem_rw_mode == WORD) begin
        mem[mem_addr + 12'd2] = mem_w_data[23:16];
        mem[mem_addr + 12'd3] = mem_w_data[31:24];
      end
    end
    if (mem_wr_en0) wr_count0++;
    if (mem_rw_mode == WORD) word_cycles++;
  end

  task automatic do_req(input bit sel, input logic we, input logic [2:0] f3,
                        input logic [11:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    if (sel) begin
      req_valid0 = 1'b1; req_we0 = we; req_funct30 = f3; req_addr0 = addr; req_wdata0 = wd;
    end else begin
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_valid0 = 1'b0;
    lat = 1;
    while (!(sel ? rsp_valid0 : rsp_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = sel ? rsp_rdata0 : rsp_rdata;
    er = sel ? rsp_err0 : rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    req_valid0 = 0; req_we0 = 0; req_funct30 = 0; req_addr0 = 0; req_wdata0 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_mem_wr_en got=%b exp=0", mem_wr_en); end
    checks++; if (mem_rw_mode !== BYTE) begin failures++; $display("FAIL reset_mode got=%b exp=%b", mem_rw_mode, BYTE); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_word;
    int lat, w0, wc;
    logic [31:0] rd;
    logic er;
    w0 = wr_count;
    do_req(0, 1'b1, F3_W, 12'h010, 32'h8899AABB, lat, rd, er);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL sw_rsp got=%h/%b exp=0/0", rd, er); end
    checks++; if (wr_count - w0 !== 1) begin failures++; $display("FAIL sw_write_count got=%0d exp=1", wr_count - w0); end
    checks++; if ({mem[12'h013], mem[12'h012], mem[12'h011], mem[12'h010]} !== 32'h8899AABB) begin
      failures++; $display("FAIL sw_mem got=%h exp=8899aabb", {mem[12'h013], mem[12'h012], mem[12'h011], mem[12'h010]});
    end
    wc = word_cycles;
    do_req(0, 1'b0, F3_W, 12'h010, 32'h0, lat, rd, er);
    checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'h8899AABB) begin failures++; $display("FAIL lw_data got=%h exp=8899aabb", rd); end
    checks++; if (word_cycles - wc !== 1) begin failures++; $display("FAIL lw_word_cycles got=%0d exp=1", word_cycles - wc); end
  endtask

  task automatic test_byte;
    int lat;
    logic [31:0] rd;
    logic er;
    do_req(0, 1'b1, F3_B, 12'h020, 32'hDEADBE7A, lat, rd, er);
    do_req(0, 1'b1, F3_B, 12'h021, 32'h123456F0, lat, rd, er);
    checks++; if (mem[12'h021] !== 8'hF0 || mem[12'h020] !== 8'h7A) begin
      failures++; $display("FAIL sb_mem got=%h%h exp=f07a", mem[12'h021], mem[12'h020]);
    end
    do_req(0, 1'b0, F3_B, 12'h021, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFFFF0 || lat !== 2) begin failures++; $display("FAIL lb got=%h lat=%0d exp=fffffff0 lat=2", rd, lat); end
    do_req(0, 1'b0, F3_BU, 12'h021, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h000000F0) begin failures++; $display("FAIL lbu got=%h exp=000000f0", rd); end
    do_req(0, 1'b0, F3_H, 12'h020, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFF07A) begin failures++; $display("FAIL lh got=%h exp=fffff07a", rd); end
    do_req(0, 1'b0, F3_HU, 12'h020, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000F07A) begin failures++; $display("FAIL lhu got=%h exp=0000f07a", rd); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_rdata !== 32'h0000F07A || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rdata_hold got=%h/%b exp=0000f07a/0", rsp_rdata, rsp_valid);
    end
  endtask

  task automatic test_split;
    int lat, w0;
    logic [31:0] rd;
    logic er;
    w0 = wr_count;
    do_req(0, 1'b1, F3_W, 12'hFFE, 32'h11223344, lat, rd, er);
    checks++; if (lat !== 5 || er !== 1'b0) begin failures++; $display("FAIL split_sw got lat=%0d err=%b exp lat=5 err=0", lat, er); end
    checks++; if (wr_count - w0 !== 4) begin failures++; $display("FAIL split_sw_writes got=%0d exp=4", wr_count - w0); end
    checks++; if ({mem[12'h001], mem[12'h000], mem[12'hFFF], mem[12'hFFE]} !== 32'h11223344) begin
      failures++; $display("FAIL split_sw_mem got=%h exp=11223344", {mem[12'h001], mem[12'h000], mem[12'hFFF], mem[12'hFFE]});
    end
    do_req(0, 1'b0, F3_W, 12'hFFE, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h11223344 || lat !== 5) begin failures++; $display("FAIL split_lw got=%h lat=%0d exp=11223344 lat=5", rd, lat); end
    do_req(0, 1'b0, F3_H, 12'hFFF, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00002233 || lat !== 3) begin failures++; $display("FAIL split_lh got=%h lat=%0d exp=00002233 lat=3", rd, lat); end
    do_req(0, 1'b1, F3_H, 12'h041, 32'h5555ABCD, lat, rd, er);
    checks++; if (lat !== 3 || mem[12'h042] !== 8'hAB || mem[12'h041] !== 8'hCD) begin
      failures++; $display("FAIL split_sh got lat=%0d mem=%h%h exp lat=3 mem=abcd", lat, mem[12'h042], mem[12'h041]);
    end
    do_req(0, 1'b0, F3_H, 12'h041, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFABCD) begin failures++; $display("FAIL split_lh_sign got=%h exp=ffffabcd", rd); end
  endtask

  task automatic test_errors;
    int lat, w0;
    logic [31:0] rd;
    logic er;
    logic [7:0] snap;
    snap = mem[12'h030];
    w0 = wr_count;
    do_req(0, 1'b1, F3_BU, 12'h030, 32'h000000FF, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      failures++; $display("FAIL store_f3_100 got err=%b rd=%h lat=%0d exp err=1 rd=0 lat=1", er, rd, lat);
    end
    checks++; if (wr_count - w0 !== 0 || mem[12'h030] !== snap) begin
      failures++; $display("FAIL store_f3_100_writes got=%0d exp=0", wr_count - w0);
    end
    do_req(0, 1'b0, 3'b111, 12'h010, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1 || lat !== 1) begin failures++; $display("FAIL load_f3_111 got err=%b lat=%0d exp err=1 lat=1", er, lat); end
    w0 = wr_count0;
    do_req(1, 1'b0, F3_W, 12'h008, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hCAFE0123 || er !== 1'b0 || lat !== 2) begin
      failures++; $display("FAIL nosplit_lw got=%h err=%b lat=%0d exp=cafe0123 err=0 lat=2", rd, er, lat);
    end
    do_req(1, 1'b0, F3_H, 12'h003, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      failures++; $display("FAIL nosplit_lh got err=%b rd=%h lat=%0d exp err=1 rd=0 lat=1", er, rd, lat);
    end
    do_req(1, 1'b0, 3'b011, 12'h004, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      failures++; $display("FAIL f3_011 got err=%b rd=%h lat=%0d exp err=1 rd=0 lat=1", er, rd, lat);
    end
    do_req(1, 1'b1, F3_W, 12'h005, 32'h12345678, lat, rd, er);
    checks++; if (er !== 1'b1 || lat !== 1 || wr_count0 - w0 !== 0) begin
      failures++; $display("FAIL nosplit_sw got err=%b lat=%0d writes=%0d exp err=1 lat=1 writes=0", er, lat, wr_count0 - w0);
    end
  endtask

  task automatic test_back_to_back;
    int acc, rsps, bad, overlap;
    acc = 0; rsps = 0; bad = 0; overlap = 0;
    req_we = 1'b0; req_funct3 = F3_W; req_addr = 12'h010; req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (req_valid && req_ready) acc++;
      if (rsp_valid) begin
        rsps++;
        if (rsp_rdata !== 32'h8899AABB) bad++;
      end
      if (rsp_valid && req_ready) overlap++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) rsps++;
      @(posedge clk); #1;
    end
    checks++; if (acc !== 10) begin failures++; $display("FAIL b2b_accepts got=%0d exp=10", acc); end
    checks++; if (rsps !== 10) begin failures++; $display("FAIL b2b_responses got=%0d exp=10", rsps); end
    checks++; if (bad !== 0 || overlap !== 0) begin failures++; $display("FAIL b2b_data bad=%0d overlap=%0d exp=0/0", bad, overlap); end
  endtask

  task automatic test_reset_mid_split;
    int lat, w0;
    logic [31:0] rd;
    logic er;
    logic [7:0] s107, s108;
    s107 = mem[12'h107];
    s108 = mem[12'h108];
    w0 = wr_count;
    req_we = 1'b1; req_funct3 = F3_W; req_addr = 12'h105; req_wdata = 32'h55667788;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (mem_wr_en !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL midreset_outputs got wr=%b vld=%b rd=%h err=%b exp all 0", mem_wr_en, rsp_valid, rsp_rdata, rsp_err);
    end
    @(posedge clk);
    @(posedge clk); #1;
    checks++; if (wr_count - w0 !== 2) begin failures++; $display("FAIL midreset_writes got=%0d exp=2", wr_count - w0); end
    checks++; if (mem[12'h105] !== 8'h88 || mem[12'h106] !== 8'h77 || mem[12'h107] !== s107 || mem[12'h108] !== s108) begin
      failures++; $display("FAIL midreset_mem got=%h %h %h %h exp=88 77 %h %h",
                           mem[12'h105], mem[12'h106], mem[12'h107], mem[12'h108], s107, s108);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", req_ready); end
    do_req(0, 1'b0, F3_BU, 12'h106, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00000077 || lat !== 2) begin failures++; $display("FAIL midreset_recover got=%h lat=%0d exp=00000077 lat=2", rd, lat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_split();
    test_errors();
    test_back_to_back();
    test_reset_mid_split();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
